// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/ROM definitions: instruction field layout, NOP/bubble word and
// fetch state encodings.
package instruction_fetch_pkg;

    localparam int OPCODE_W    = 4;
    localparam int DEST_W      = 8;
    localparam int SRC_SHORT_W = 8;
    localparam int SRC_LONG_W  = 16;
    localparam int OPERAND_W   = DEST_W + SRC_LONG_W;
    localparam int WORD_W      = OPCODE_W + OPERAND_W;

    localparam logic [OPCODE_W-1:0] NOP_OPCODE = 4'hF;
    localparam logic [WORD_W-1:0]   BUBBLE     = {NOP_OPCODE, {OPERAND_W{1'b0}}};

    // The unused fourth encoding (2'b11) is recovered to ST_START by the FSM.
    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: ROM address/data, downstream stall/redirect and the
// registered instruction handed to decode.
interface instruction_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int INSN_W = 28
);
    // stall=1 freezes the stage (decode not ready); fetch_valid=1 marks a real
    // fetch, 0 a bubble. redirect is sampled only at the clock edge and wins
    // over stall; the stage never back-pressures the ROM, which answers
    // combinationally for the address presented in the same cycle.
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] address;
    logic [INSN_W-1:0] rom_data;
    logic [INSN_W-1:0] fetch_insn;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_valid;

    modport master (
        input  stall, redirect, redirect_target, rom_data,
        output address, fetch_insn, fetch_pc, fetch_valid
    );

    modport slave (
        output stall, redirect, redirect_target, rom_data,
        input  address, fetch_insn, fetch_pc, fetch_valid
    );

endinterface

// File: rtl/instruction_fetch_pc_register.sv
// Program counter with async active-low reset; load beats increment, otherwise
// the value holds. Its output is the ROM address.
module instruction_fetch_pc_register #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // Natural modulo-2^ADDR_W wrap, no overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register driving the ROM, fetch register toward decode, and
// the START/RUN/FLUSH machine that handles stalls and redirect bubbles.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                ADDR_W       = 16,
    parameter int                INSN_W       = 28,
    parameter int                FLUSH_CYCLES = 2,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master bus,
    output fetch_state_t        fsm_state
);

    localparam logic [INSN_W-1:0] BUBBLE_WORD = {NOP_OPCODE, {(INSN_W-OPCODE_W){1'b0}}};
    localparam logic [3:0]        FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);

    fetch_state_t      state_q;
    logic [3:0]        flush_cnt;
    logic [INSN_W-1:0] out_insn;
    logic [ADDR_W-1:0] out_pc;
    logic              out_valid;
    logic [ADDR_W-1:0] pc;
    logic              pc_inc;

    // The PC only advances when a ROM word is actually captured.
    assign pc_inc = (state_q == ST_RUN) && !bus.stall && !bus.redirect;

    instruction_fetch_pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (bus.redirect),
        .target (bus.redirect_target),
        .inc    (pc_inc),
        .pc     (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_START;
            flush_cnt <= '0;
            out_insn  <= BUBBLE_WORD;
            out_pc    <= '0;
            out_valid <= 1'b0;
        end else if (bus.redirect) begin
            // The redirect cycle itself is the first of the FLUSH_CYCLES bubbles.
            out_insn  <= BUBBLE_WORD;
            out_pc    <= '0;
            out_valid <= 1'b0;
            flush_cnt <= FLUSH_LOAD;
            state_q   <= (FLUSH_LOAD != 4'd0) ? ST_FLUSH : ST_RUN;
        end else begin
            case (state_q)
                ST_START: begin
                    out_insn  <= BUBBLE_WORD;
                    out_pc    <= '0;
                    out_valid <= 1'b0;
                    state_q   <= ST_RUN;
                end
                ST_RUN: begin
                    if (!bus.stall) begin
                        out_insn  <= bus.rom_data;
                        out_pc    <= pc;
                        out_valid <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (!bus.stall) begin
                        out_insn  <= BUBBLE_WORD;
                        out_pc    <= '0;
                        out_valid <= 1'b0;
                        flush_cnt <= flush_cnt - 4'd1;
                        if (flush_cnt <= 4'd1) begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                default: begin
                    out_insn  <= BUBBLE_WORD;
                    out_pc    <= '0;
                    out_valid <= 1'b0;
                    state_q   <= ST_START;
                end
            endcase
        end
    end

    assign bus.address     = pc;
    assign bus.fetch_insn  = out_insn;
    assign bus.fetch_pc    = out_pc;
    assign bus.fetch_valid = out_valid;
    assign fsm_state       = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, stall, redirect,
// redirect-under-stall, redirect during flush, PC wrap and async reset.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam logic [27:0] BUB = 28'hF000000;

    logic clk;
    logic rst_n;
    fetch_state_t fsm_state;
    int total = 0;
    int bad = 0;

    instruction_fetch_if #(.ADDR_W(16), .INSN_W(28)) bus ();

    instruction_fetch #(
        .ADDR_W       (16),
        .INSN_W       (28),
        .FLUSH_CYCLES (2),
        .RESET_PC     (16'h0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ROM model: word at address a is {opcode 3, 8'hA5, a}.
    function automatic logic [27:0] rom_word(input logic [15:0] a);
        return {4'h3, 8'hA5, a};
    endfunction

    assign bus.rom_data = rom_word(bus.address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = 16'h0000;
        tick();
        tick();
        total++;
        if ({bus.fetch_valid, bus.fetch_pc, bus.fetch_insn} !== {1'b0, 16'h0000, BUB}) begin
            bad++;
            $display("FAIL reset_out got v=%b pc=%h insn=%h want v=0 pc=0000 insn=%h",
                     bus.fetch_valid, bus.fetch_pc, bus.fetch_insn, BUB);
        end
        total++;
        if (bus.address !== 16'h0000 || fsm_state !== ST_START) begin
            bad++;
            $display("FAIL reset_state got addr=%h st=%0d want addr=0000 st=%0d",
                     bus.address, fsm_state, ST_START);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_run();
        tick();
        total++;
        if (bus.fetch_valid !== 1'b0 || fsm_state !== ST_RUN || bus.address !== 16'h0000) begin
            bad++;
            $display("FAIL start_bubble got v=%b st=%0d addr=%h want v=0 st=%0d addr=0000",
                     bus.fetch_valid, fsm_state, bus.address, ST_RUN);
        end
        for (int k = 0; k < 6; k++) begin
            logic [15:0] kk;
            kk = 16'(k);
            tick();
            total++;
            if ({bus.fetch_valid, bus.fetch_pc, bus.fetch_insn, bus.address} !==
                {1'b1, kk, rom_word(kk), kk + 16'd1}) begin
                bad++;
                $display("FAIL run_seq got v=%b pc=%h insn=%h addr=%h want pc=%h",
                         bus.fetch_valid, bus.fetch_pc, bus.fetch_insn, bus.address, kk);
            end
        end
    endtask

    task automatic test_stall();
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({bus.fetch_valid, bus.fetch_pc, bus.fetch_insn, bus.address} !==
                {1'b1, 16'd5, rom_word(16'd5), 16'd6}) begin
                bad++;
                $display("FAIL stall_hold got v=%b pc=%h insn=%h addr=%h want pc=0005 addr=0006",
                         bus.fetch_valid, bus.fetch_pc, bus.fetch_insn, bus.address);
            end
        end
        bus.stall = 1'b0;
        for (int k = 6; k < 16; k++) begin
            logic [15:0] kk;
            kk = 16'(k);
            tick();
            total++;
            if ({bus.fetch_valid, bus.fetch_pc, bus.fetch_insn} !== {1'b1, kk, rom_word(kk)}) begin
                bad++;
                $display("FAIL stall_resume got v=%b pc=%h insn=%h want pc=%h",
                         bus.fetch_valid, bus.fetch_pc, bus.fetch_insn, kk);
            end
        end
    endtask

    task automatic test_redirect();
        total++;
        if (bus.address !== 16'd16) begin
            bad++;
            $display("FAIL redir_pre got addr=%h want 0010", bus.address);
        end
        bus.redirect = 1'b1;
        bus.redirect_target = 16'h0002;
        tick();
        bus.redirect = 1'b0;
        total++;
        if ({bus.fetch_valid, bus.fetch_pc, bus.fetch_insn, bus.address} !== {1'b0, 16'h0, BUB, 16'h2}
            || fsm_state !== ST_FLUSH) begin
            bad++;
            $display("FAIL redir_bubble1 got v=%b pc=%h insn=%h addr=%h st=%0d want bubble addr=0002 FLUSH",
                     bus.fetch_valid, bus.fetch_pc, bus.fetch_insn, bus.address, fsm_state);
        end
        tick();
        total++;
        if ({bus.fetch_valid, bus.fetch_insn, bus.address} !== {1'b0, BUB, 16'h2} || fsm_state !== ST_RUN) begin
            bad++;
            $display("FAIL redir_bubble2 got v=%b insn=%h addr=%h st=%0d want bubble addr=0002 RUN",
                     bus.fetch_valid, bus.fetch_insn, bus.address, fsm_state);
        end
        for (int k = 2; k < 4; k++) begin
            logic [15:0] kk;
            kk = 16'(k);
            tick();
            total++;
            if ({bus.fetch_valid, bus.fetch_pc, bus.fetch_insn} !== {1'b1, kk, rom_word(kk)}) begin
                bad++;
                $display("FAIL redir_target got v=%b pc=%h insn=%h want pc=%h",
                         bus.fetch_valid, bus.fetch_pc, bus.fetch_insn, kk);
            end
        end
    endtask

    task automatic test_redirect_stall();
        bus.stall = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_target = 16'h0020;
        tick();
        bus.redirect = 1'b0;
        total++;
        if ({bus.fetch_valid, bus.fetch_insn, bus.address} !== {1'b0, BUB, 16'h20} || fsm_state !== ST_FLUSH) begin
            bad++;
            $display("FAIL rs_taken got v=%b insn=%h addr=%h st=%0d want bubble addr=0020 FLUSH",
                     bus.fetch_valid, bus.fetch_insn, bus.address, fsm_state);
        end
        tick();
        total++;
        if (bus.fetch_valid !== 1'b0 || fsm_state !== ST_FLUSH || bus.address !== 16'h20) begin
            bad++;
            $display("FAIL rs_flush_hold got v=%b st=%0d addr=%h want v=0 FLUSH addr=0020",
                     bus.fetch_valid, fsm_state, bus.address);
        end
        bus.stall = 1'b0;
        tick();
        total++;
        if (bus.fetch_valid !== 1'b0 || fsm_state !== ST_RUN) begin
            bad++;
            $display("FAIL rs_bubble2 got v=%b st=%0d want v=0 RUN", bus.fetch_valid, fsm_state);
        end
        tick();
        total++;
        if ({bus.fetch_valid, bus.fetch_pc, bus.fetch_insn} !== {1'b1, 16'h20, rom_word(16'h20)}) begin
            bad++;
            $display("FAIL rs_target got v=%b pc=%h insn=%h want pc=0020",
                     bus.fetch_valid, bus.fetch_pc, bus.fetch_insn);
        end
    endtask

    task automatic test_double_redirect();
        bus.redirect = 1'b1;
        bus.redirect_target = 16'h0030;
        tick();
        bus.redirect_target = 16'h0040;
        tick();
        bus.redirect = 1'b0;
        total++;
        if ({bus.fetch_valid, bus.address} !== {1'b0, 16'h40} || fsm_state !== ST_FLUSH) begin
            bad++;
            $display("FAIL dbl_reload got v=%b addr=%h st=%0d want v=0 addr=0040 FLUSH",
                     bus.fetch_valid, bus.address, fsm_state);
        end
        tick();
        total++;
        if (bus.fetch_valid !== 1'b0 || fsm_state !== ST_RUN) begin
            bad++;
            $display("FAIL dbl_bubble2 got v=%b st=%0d want v=0 RUN", bus.fetch_valid, fsm_state);
        end
        tick();
        total++;
        if ({bus.fetch_valid, bus.fetch_pc, bus.fetch_insn} !== {1'b1, 16'h40, rom_word(16'h40)}) begin
            bad++;
            $display("FAIL dbl_target got v=%b pc=%h insn=%h want pc=0040",
                     bus.fetch_valid, bus.fetch_pc, bus.fetch_insn);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [3];
        exp_pc[0] = 16'hFFFE;
        exp_pc[1] = 16'hFFFF;
        exp_pc[2] = 16'h0000;
        bus.redirect = 1'b1;
        bus.redirect_target = 16'hFFFE;
        tick();
        bus.redirect = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({bus.fetch_valid, bus.fetch_pc, bus.fetch_insn, bus.address} !==
                {1'b1, exp_pc[k], rom_word(exp_pc[k]), exp_pc[k] + 16'd1}) begin
                bad++;
                $display("FAIL wrap got v=%b pc=%h insn=%h addr=%h want pc=%h",
                         bus.fetch_valid, bus.fetch_pc, bus.fetch_insn, bus.address, exp_pc[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.fetch_valid, bus.address, bus.fetch_pc} !== {1'b0, 16'h0, 16'h0} || fsm_state !== ST_START) begin
            bad++;
            $display("FAIL async_reset got v=%b addr=%h pc=%h st=%0d want v=0 addr=0000 pc=0000 START",
                     bus.fetch_valid, bus.address, bus.fetch_pc, fsm_state);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.fetch_valid, bus.fetch_pc, bus.fetch_insn} !== {1'b1, 16'h0, rom_word(16'h0)}) begin
            bad++;
            $display("FAIL post_reset got v=%b pc=%h insn=%h want pc=0000",
                     bus.fetch_valid, bus.fetch_pc, bus.fetch_insn);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_double_redirect();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Program-counter and fetch-register stage directly upstream of the instruction ROM.
- Drives the ROM address, registers the returned 28-bit instruction word together with its PC, and hands it to decode.
- Handles stalls from downstream, branch/jump redirects and the bubble insertion that follows a redirect.
- Keeps NOP padding out of the program image.

Parameters:
- ADDR_W, 16, PC / ROM address width.
- INSN_W, 28, instruction word width (4-bit opcode + 24-bit operand field).
- FLUSH_CYCLES, 2, total bubble cycles emitted per redirect, including the redirect cycle; legal range 1..15.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- iStall  input  1  decode cannot accept; freeze the stage.
- iRedirect  input  1  taken branch/jump from downstream.
- iRedirectTarget  input  ADDR_W  new PC when iRedirect=1.
- oAddress  output  ADDR_W  ROM address; combinational copy of the PC register.
- iInstruction  input  INSN_W  ROM data for oAddress; combinational, same cycle.
- oInstruction  output  INSN_W  registered instruction to decode.
- oPC  output  ADDR_W  address of oInstruction.
- oValid  output  1  oInstruction is a real fetch, not a bubble.

Behaviour:
- Reset asserted (Reset=0, asynchronous):
  - PC=RESET_PC, state=START, flush counter=0.
  - oInstruction=BUBBLE ({NOP opcode, 24'd0}), oPC=0, oValid=0.
- START:
  - One cycle after reset release.
  - Emits a bubble and holds the PC, then goes to RUN (unless iRedirect=1, which is handled as below).
- RUN, iStall=0, iRedirect=0:
  - oInstruction<=iInstruction, oPC<=PC, oValid<=1, PC<=PC+1.
  - Fetch-to-output latency is 1 cycle; throughput is 1 instruction per cycle.
- RUN, iStall=1, iRedirect=0: PC, oInstruction, oPC and oValid all hold. No ROM word is lost; the same address is re-presented.
- Redirect (iRedirect=1, any state, any iStall):
  - Redirect has priority over stall and over flush.
  - PC<=iRedirectTarget, oInstruction<=BUBBLE, oValid<=0, oPC<=0.
  - Counter<=FLUSH_CYCLES-1. Next state is FLUSH if the counter is nonzero, else RUN.
- FLUSH, iStall=0:
  - Emit BUBBLE with oValid=0, hold PC, decrement the counter.
  - When the counter reaches 0, the next state is RUN; the first RUN cycle fetches at the target.
- FLUSH, iStall=1: counter, PC and outputs hold.
- Redirect during FLUSH: reload the target and counter; there is no accumulation.
- PC wrap: 16'hFFFF+1 = 16'h0000, modulo 2^ADDR_W, with no flag.
- Redirect target equal to the current PC: legal; it re-fetches after the flush.
- Reset mid-FLUSH or mid-stall: all state is immediately forced to reset values.
- oAddress always equals the PC register; it never glitches on iRedirect, which takes effect only at the clock edge.
- States: START, RUN, FLUSH, encoded in 2 bits; the fourth encoding recovers to START.

Decomposition:
- Shared definitions header (same one the ROM uses): NOP opcode, BUBBLE word constant, instruction field widths (opcode 4, dest 8, src 8/16), fetch state encodings.
- One natural sub-module: pc_register. It holds the PC with async active-low reset, load (redirect), increment and hold enables, and drives oAddress.
- The state machine, flush counter and output register stay in instruction_fetch.

Test Plan:
- Reset release, no stall, ROM returning word k at address k:
  - Cycle 1 is a bubble with oValid=0.
  - Then oPC=0,1,2,3 with matching oInstruction and oValid=1 each cycle.
- Stall for 3 cycles while oPC=5:
  - oPC=5 and oInstruction are held for 3 cycles, with oAddress=6 throughout.
  - After release the sequence resumes with oPC=6; no skips or duplicates.
- Redirect to 16'h0002 at PC=16, FLUSH_CYCLES=2:
  - Two bubbles with oValid=0.
  - Then oPC=2,3,… with valid instructions.
- Redirect with iStall=1 in the same cycle: the redirect is taken, and the next valid output is at the target address after the bubbles.
- Second redirect to 16'h0040 during FLUSH: the counter restarts, and the first valid oPC is 16'h0040 after 2 total bubbles from the second redirect.
- Wrap and async reset:
  - Redirect to 16'hFFFE; oPC sequence is FFFE, FFFF, 0000.
  - Dropping Reset mid-run forces oValid=0 and oAddress=0 immediately, without waiting for a clock edge.
